// File: rtl/board_game_ctrl.sv
// board_game_ctrl: N x N, K-in-a-row two-player game engine.
//
// Moves arrive over a valid/ready handshake. Illegal moves are rejected with
// a one-cycle move_err pulse. Accepted moves pulse move_ack and are checked
// for a win or a draw one cycle later.
//
// Optional feature: define BOARD_GAME_UNDO_EN to enable a single-level undo
// of the last accepted move. Without it the undo port is ignored.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   new_game   in   synchronous restart; beats move_valid and undo
//   move_valid in   move request
//   move_pos   in   POS_W  1-based row-major cell index (0 is invalid)
//   undo       in   undo request (only with BOARD_GAME_UNDO_EN)
//   move_ready out  engine accepts a move this cycle
//   move_ack   out  one-cycle pulse: move (or undo) accepted
//   move_err   out  one-cycle pulse: move (or undo) rejected
//   turn       out  0 = X to move, 1 = O to move
//   winner     out  2  00 none, 01 X, 10 O, 11 draw
//   game_over  out  game finished
//   move_count out  POS_W  marks on board
//   board      out  2*N*N  cell i at bits [2i-1:2i-2]; 00 empty, 01 X, 10 O
//
// state | meaning
// PLAY  | waiting for a move (or undo); move_ready=1
// CHECK | one cycle: scan lines through the last move for a win or draw
// DONE  | game finished; moves ignored until new_game or rst

module board_game_ctrl #(
  parameter int N     = 3,
  parameter int K     = 3,
  parameter int POS_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               new_game,
  input  logic               move_valid,
  input  logic [POS_W-1:0]   move_pos,
  input  logic               undo,
  output logic               move_ready,
  output logic               move_ack,
  output logic               move_err,
  output logic               turn,
  output logic [1:0]         winner,
  output logic               game_over,
  output logic [POS_W-1:0]   move_count,
  output logic [2*N*N-1:0]   board
);

  localparam int CELLS = N * N;
  localparam int BW    = 2 * CELLS;
  localparam logic [POS_W-1:0] CELLS_P = POS_W'(CELLS);

  typedef enum logic [1:0] {PLAY, CHECK, DONE} state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    board_q, board_d;
  logic             turn_q, turn_d;
  logic [1:0]       winner_q, winner_d;
  logic [POS_W-1:0] count_q, count_d;
  logic [POS_W-1:0] last_pos_q, last_pos_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic [1:0]       mover_mark;
  logic [1:0]       tgt_cell;
  logic             move_legal;
  logic             win;
  int               last_idx;

  function automatic logic [1:0] cell_at(input logic [BW-1:0] b, input int idx);
    logic [BW-1:0] sh;
    sh = b >> (2 * idx);
    return sh[1:0];
  endfunction

  function automatic logic in_run(input logic [BW-1:0] b, input int r, input int c,
                                  input logic [1:0] m);
    if (r < 0 || r >= N || c < 0 || c >= N) return 1'b0;
    return cell_at(b, r * N + c) == m;
  endfunction

  assign mover_mark = turn_q ? 2'b10 : 2'b01;
  assign tgt_cell   = cell_at(board_q, int'(move_pos) - 1);
  assign move_legal = (move_pos != '0) && (move_pos <= CELLS_P) && (tgt_cell == 2'b00);
  assign last_idx   = (last_pos_q == '0) ? 0 : int'(last_pos_q) - 1;

  // Run length along each of the four line directions through the last move,
  // walking outward both ways and stopping at the board edge (no row wrap).
  always_comb begin
    int row, col, r, c, dr, dc, run;
    logic fwd_ok, bwd_ok;
    logic [1:0] last_mark;
    win       = 1'b0;
    row       = last_idx / N;
    col       = last_idx % N;
    last_mark = cell_at(board_q, last_idx);
    for (int d = 0; d < 4; d++) begin
      case (d)
        0:       begin dr = 0; dc = 1;  end
        1:       begin dr = 1; dc = 0;  end
        2:       begin dr = 1; dc = 1;  end
        default: begin dr = 1; dc = -1; end
      endcase
      run    = 1;
      fwd_ok = 1'b1;
      bwd_ok = 1'b1;
      for (int s = 1; s < K; s++) begin
        r = row + s * dr;
        c = col + s * dc;
        if (fwd_ok && in_run(board_q, r, c, last_mark)) run = run + 1;
        else fwd_ok = 1'b0;
        r = row - s * dr;
        c = col - s * dc;
        if (bwd_ok && in_run(board_q, r, c, last_mark)) run = run + 1;
        else bwd_ok = 1'b0;
      end
      if (run >= K && last_mark != 2'b00) win = 1'b1;
    end
  end

`ifdef BOARD_GAME_UNDO_EN
  logic slot_q, slot_d;
`else
  logic undo_unused;
  assign undo_unused = undo;
`endif

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    turn_d     = turn_q;
    winner_d   = winner_q;
    count_d    = count_q;
    last_pos_d = last_pos_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
`ifdef BOARD_GAME_UNDO_EN
    slot_d     = slot_q;
`endif
    if (new_game) begin
      state_d    = PLAY;
      board_d    = '0;
      turn_d     = 1'b0;
      winner_d   = 2'b00;
      count_d    = '0;
      last_pos_d = '0;
`ifdef BOARD_GAME_UNDO_EN
      slot_d     = 1'b0;
`endif
    end else begin
      case (state_q)
        PLAY: begin
`ifdef BOARD_GAME_UNDO_EN
          // Undo beats a simultaneous move; the move is dropped silently.
          if (undo) begin
            if (slot_q) begin
              board_d = board_q & ~({{(BW-2){1'b0}}, 2'b11} << (2 * last_idx));
              count_d = count_q - POS_W'(1);
              turn_d  = ~turn_q;
              slot_d  = 1'b0;
              ack_d   = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else
`endif
          if (move_valid) begin
            if (move_legal) begin
              board_d    = board_q | ({{(BW-2){1'b0}}, mover_mark} << (2 * (int'(move_pos) - 1)));
              count_d    = count_q + POS_W'(1);
              last_pos_d = move_pos;
              ack_d      = 1'b1;
              state_d    = CHECK;
`ifdef BOARD_GAME_UNDO_EN
              slot_d     = 1'b1;
`endif
            end else begin
              err_d = 1'b1;
            end
          end
        end
        CHECK: begin
          // turn_q still names the player who just moved.
          if (win) begin
            winner_d = mover_mark;
            state_d  = DONE;
          end else if (count_q == CELLS_P) begin
            winner_d = 2'b11;
            state_d  = DONE;
          end else begin
            turn_d  = ~turn_q;
            state_d = PLAY;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = PLAY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PLAY;
      board_q    <= '0;
      turn_q     <= 1'b0;
      winner_q   <= 2'b00;
      count_q    <= '0;
      last_pos_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
`ifdef BOARD_GAME_UNDO_EN
      slot_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      turn_q     <= turn_d;
      winner_q   <= winner_d;
      count_q    <= count_d;
      last_pos_q <= last_pos_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
`ifdef BOARD_GAME_UNDO_EN
      slot_q     <= slot_d;
`endif
    end
  end

  assign move_ready = (state_q == PLAY);
  assign game_over  = (state_q == DONE);
  assign move_ack   = ack_q;
  assign move_err   = err_q;
  assign turn       = turn_q;
  assign winner     = winner_q;
  assign move_count = count_q;
  assign board      = board_q;

endmodule

// File: tb/tb_board_game_ctrl.sv
// Testbench for board_game_ctrl: a 3x3/K=3 instance and a 5x5/K=4 instance.
// Exercises the BOARD_GAME_UNDO_EN path when that macro is defined.

module tb_board_game_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ng3, mv3, un3, mr3, ack3, err3, turn3, go3;
  logic [3:0]  mp3, cnt3;
  logic [1:0]  win3;
  logic [17:0] brd3;
  logic        ng5, mv5, un5, mr5, ack5, err5, turn5, go5;
  logic [4:0]  mp5, cnt5;
  logic [1:0]  win5;
  logic [49:0] brd5;

  board_game_ctrl #(.N(3), .K(3), .POS_W(4)) u_d3 (
    .clk(clk), .rst(rst), .new_game(ng3), .move_valid(mv3), .move_pos(mp3),
    .undo(un3), .move_ready(mr3), .move_ack(ack3), .move_err(err3),
    .turn(turn3), .winner(win3), .game_over(go3), .move_count(cnt3), .board(brd3));

  board_game_ctrl #(.N(5), .K(4), .POS_W(5)) u_d5 (
    .clk(clk), .rst(rst), .new_game(ng5), .move_valid(mv5), .move_pos(mp5),
    .undo(un5), .move_ready(mr5), .move_ack(ack5), .move_err(err5),
    .turn(turn5), .winner(win5), .game_over(go5), .move_count(cnt5), .board(brd5));

  typedef struct {
    string      tag;
    logic [1:0] exp;
  } sb_t;

  sb_t         sb[$];
  int          total = 0;
  int          bad = 0;
  logic [17:0] m3;
  logic [49:0] m5;
  logic        mt3, mt5;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // exp = {ack, err} expected in the cycle after the request edge.
  task automatic do_move(input bit big, input int pos, input logic [1:0] exp, input string tag);
    sb_t e;
    @(negedge clk);
    if (big) begin mv5 = 1'b1; mp5 = 5'(pos); end
    else     begin mv3 = 1'b1; mp3 = 4'(pos); end
    sb.push_back('{tag, exp});
    if (exp == 2'b10) begin
      if (big) begin m5[2*(pos-1) +: 2] = mt5 ? 2'b10 : 2'b01; mt5 = ~mt5; end
      else     begin m3[2*(pos-1) +: 2] = mt3 ? 2'b10 : 2'b01; mt3 = ~mt3; end
    end
    @(posedge clk); #1;
    mv3 = 1'b0; mv5 = 1'b0;
    @(negedge clk);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk(e.tag, big ? {ack5, err5} : {ack3, err3}, e.exp);
    end
    if (exp == 2'b10) begin
      chk({tag, "_ready_low"}, big ? mr5 : mr3, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic new_game(input bit big);
    @(negedge clk);
    if (big) ng5 = 1'b1; else ng3 = 1'b1;
    @(posedge clk); #1;
    ng3 = 1'b0; ng5 = 1'b0;
    if (big) begin m5 = '0; mt5 = 1'b0; end
    else     begin m3 = '0; mt3 = 1'b0; end
  endtask

`ifdef BOARD_GAME_UNDO_EN
  task automatic do_undo(input logic [1:0] exp, input string tag);
    sb_t e;
    @(negedge clk);
    un3 = 1'b1;
    sb.push_back('{tag, exp});
    @(posedge clk); #1;
    un3 = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    chk(e.tag, {ack3, err3}, e.exp);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    sb_t e;
    rst = 1'b1;
    {ng3, mv3, un3, ng5, mv5, un5} = '0;
    mp3 = '0; mp5 = '0;
    m3 = '0; m5 = '0; mt3 = 1'b0; mt5 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_board",  brd3, 18'd0);
    chk("rst_turn",   turn3, 1'b0);
    chk("rst_winner", win3, 2'b00);
    chk("rst_over",   go3, 1'b0);
    chk("rst_count",  cnt3, 4'd0);
    chk("rst_ackerr", {ack3, err3}, 2'b00);
    chk("rst_ready",  mr3, 1'b1);
    rst = 1'b0;

    // 1: X wins on column 2-5-8; later move ignored
    do_move(0, 2, 2'b10, "t1_x2");
    do_move(0, 3, 2'b10, "t1_o3");
    do_move(0, 5, 2'b10, "t1_x5");
    do_move(0, 7, 2'b10, "t1_o7");
    do_move(0, 8, 2'b10, "t1_x8");
    chk("t1_winner", win3, 2'b01);
    chk("t1_over",   go3, 1'b1);
    chk("t1_count",  cnt3, 4'd5);
    chk("t1_board",  brd3, m3);
    do_move(0, 1, 2'b00, "t1_done_ignored");
    chk("t1_board_hold", brd3, m3);
    chk("t1_count_hold", cnt3, 4'd5);

    // 2: O wins on row 4-5-6
    new_game(0);
    chk("t2_cleared", {go3, win3, cnt3, brd3}, '0);
    do_move(0, 2, 2'b10, "t2_x2");
    do_move(0, 5, 2'b10, "t2_o5");
    do_move(0, 3, 2'b10, "t2_x3");
    do_move(0, 4, 2'b10, "t2_o4");
    do_move(0, 9, 2'b10, "t2_x9");
    do_move(0, 6, 2'b10, "t2_o6");
    chk("t2_winner", win3, 2'b10);
    chk("t2_turn",   turn3, 1'b1);
    chk("t2_over",   go3, 1'b1);
    chk("t2_board",  brd3, m3);

    // 3: full board, draw
    new_game(0);
    do_move(0, 1, 2'b10, "t3_x1");
    do_move(0, 2, 2'b10, "t3_o2");
    do_move(0, 3, 2'b10, "t3_x3");
    do_move(0, 5, 2'b10, "t3_o5");
    do_move(0, 4, 2'b10, "t3_x4");
    do_move(0, 7, 2'b10, "t3_o7");
    do_move(0, 8, 2'b10, "t3_x8");
    do_move(0, 9, 2'b10, "t3_o9");
    do_move(0, 6, 2'b10, "t3_x6");
    chk("t3_winner", win3, 2'b11);
    chk("t3_count",  cnt3, 4'd9);
    chk("t3_over",   go3, 1'b1);

    // 4: illegal moves
    new_game(0);
    do_move(0, 0,  2'b01, "t4_pos0");
    do_move(0, 10, 2'b01, "t4_pos10");
    do_move(0, 5,  2'b10, "t4_x5");
    do_move(0, 5,  2'b01, "t4_occupied");
    chk("t4_board", brd3, m3);
    chk("t4_turn",  turn3, mt3);
    chk("t4_count", cnt3, 4'd1);
    do_move(0, 1, 2'b10, "t4_o1");
    chk("t4_count2", cnt3, 4'd2);
    chk("t4_turn2",  turn3, mt3);
    chk("t4_board2", brd3, m3);

    // 5: 5x5, K=4 diagonal win, then no wrap across rows
    do_move(1, 2,  2'b10, "t5_x2");
    do_move(1, 1,  2'b10, "t5_o1");
    do_move(1, 8,  2'b10, "t5_x8");
    do_move(1, 3,  2'b10, "t5_o3");
    do_move(1, 14, 2'b10, "t5_x14");
    do_move(1, 5,  2'b10, "t5_o5");
    do_move(1, 20, 2'b10, "t5_x20");
    chk("t5_diag_winner", win5, 2'b01);
    chk("t5_diag_over",   go5, 1'b1);
    new_game(1);
    do_move(1, 4,  2'b10, "t5_x4");
    do_move(1, 11, 2'b10, "t5_o11");
    do_move(1, 5,  2'b10, "t5_x5");
    do_move(1, 16, 2'b10, "t5_o16");
    do_move(1, 6,  2'b10, "t5_x6");
    do_move(1, 21, 2'b10, "t5_o21");
    do_move(1, 7,  2'b10, "t5_x7");
    chk("t5_wrap_winner", win5, 2'b00);
    chk("t5_wrap_over",   go5, 1'b0);
    chk("t5_wrap_turn",   turn5, 1'b1);
    chk("t5_wrap_count",  cnt5, 5'd7);
    chk("t5_wrap_board",  brd5, m5);

    // 6: async reset during CHECK, then new_game beating move_valid
    new_game(0);
    @(negedge clk);
    mv3 = 1'b1; mp3 = 4'd5;
    @(posedge clk); #1;
    mv3 = 1'b0;
    chk("t6_in_check", mr3, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_outputs", {go3, win3, turn3, cnt3, brd3, ack3, err3}, '0);
    chk("t6_rst_ready", mr3, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    m3 = '0; mt3 = 1'b0; m5 = '0; mt5 = 1'b0;
    @(negedge clk);
    ng3 = 1'b1; mv3 = 1'b1; mp3 = 4'd3;
    sb.push_back('{"t6_ng_drop", 2'b00});
    @(posedge clk); #1;
    ng3 = 1'b0; mv3 = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    chk(e.tag, {ack3, err3}, e.exp);
    chk("t6_ng_board", brd3, 18'd0);
    chk("t6_ng_count", cnt3, 4'd0);
    chk("t6_ng_ready", mr3, 1'b1);

`ifdef BOARD_GAME_UNDO_EN
    do_move(0, 5, 2'b10, "u_x5");
    do_undo(2'b10, "u_undo1");
    m3 = '0; mt3 = 1'b0;
    chk("u_board", brd3, m3);
    chk("u_turn",  turn3, 1'b0);
    chk("u_count", cnt3, 4'd0);
    do_undo(2'b01, "u_undo2_err");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/board_game_ctrl.md
Name: board_game_ctrl

Overview:
Parametrised N×N, K-in-a-row two-player game engine. It is the successor to the fixed 3×3 tic_tac_toe block.
- Accepts moves through a valid/ready handshake and tracks turn and board state.
- Rejects illegal moves and reports win or draw.
- Sits between the move-entry front end (keypad/test driver) and the display/score logic.

Parameters:
N, 3, board side length (3..8)
K, 3, contiguous marks needed to win (2..N)
POS_W, 4, move index width; must satisfy 2^POS_W > N*N

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
new_game  in  1  synchronous restart request
move_valid  in  1  move request
move_pos  in  POS_W  cell index, 1-based, row-major (1..N*N); 0 is invalid
undo  in  1  undo request (used only with UNDO_EN)
move_ready  out  1  engine can accept a move
move_ack  out  1  one-cycle pulse: move accepted
move_err  out  1  one-cycle pulse: move rejected
turn  out  1  0 = X to move, 1 = O to move
winner  out  2  00 none, 01 X, 10 O, 11 draw
game_over  out  1  game finished
move_count  out  POS_W  marks on board
board  out  2*N*N  cell i at bits [2i-1:2i-2]; 00 empty, 01 X, 10 O

Behaviour:
- Reset (async, rst=1): board all 00, turn=0, winner=00, game_over=0, move_count=0, move_ack=0, move_err=0, state=PLAY.
- States and outputs:
  - PLAY: move_ready=1.
  - CHECK: move_ready=0.
  - DONE: move_ready=0, game_over=1.
- PLAY, edge with move_valid=1:
  - Illegal move (move_pos=0, move_pos>N*N, or target cell not 00): move_err=1 next cycle. Board, turn and count unchanged. Stay in PLAY.
  - Legal move: write the current player's mark, move_count+1, latch last_pos, move_ack=1 next cycle, go to CHECK.
- CHECK (exactly one cycle), evaluated combinationally on the cell at last_pos:
  - Evaluate horizontal, vertical, diagonal and anti-diagonal lines through last_pos.
  - For each line, compute the contiguous same-mark run length including last_pos, clipped at board edges. No wrap across rows or columns.
  - Any run ≥ K: winner = mover (01/10), go to DONE.
  - Else if move_count = N*N: winner=11, go to DONE.
  - Else toggle turn, return to PLAY.
- Latency: move accepted at edge E. winner/turn update at edge E+1. move_ready is low for one cycle after E, so the next move can be accepted at edge E+2.
- DONE: move_valid is ignored (no err, no ack). Outputs hold until new_game or rst.
- new_game=1 at any edge, in any state: same clearing as reset, next state PLAY. It has priority over move_valid and undo in the same cycle; that move is dropped with no ack and no err.
- move_valid with move_pos held after the handshake: each PLAY-state edge is a new request. The front end deasserts move_valid after move_ack.
- move_ack and move_err are never both high.
- move_count never exceeds N*N.

Optional Feature:
- Macro: BOARD_GAME_UNDO_EN.
- Defined: undo=1 in PLAY with a valid undo slot:
  - Clear the cell at last_pos, move_count−1, toggle turn back, invalidate the slot, move_ack pulse.
  - Valid slot means the last accepted move has not yet been undone.
  - undo with no valid slot (second consecutive undo, or move_count=0): move_err pulse.
  - undo in CHECK or DONE: ignored.
  - undo and move_valid together: undo wins; the move is dropped silently.
- Undefined: the undo port is present but ignored. No last-move validity state is built.

Test Plan:
1. N=3,K=3: X2,O3,X5,O7,X8 → after the fifth move, winner=01, game_over=1, move_count=5. A further move gives no ack and no err.
2. new_game, then X2,O5,X3,O4,X9,O6 → winner=10 (row 4-5-6), turn=1 at finish.
3. new_game, then X1,O2,X3,O5,X4,O7,X8,O9,X6 → winner=11, move_count=9.
4. Illegal moves: pos 0, pos 10, and an occupied cell → move_err pulse each time; board, turn and move_count unchanged; a legal move then gets move_ack.
5. N=5,K=4,POS_W=5: X on 2,8,14,20 (diagonal) with O elsewhere → winner=01. X on 4,5,6,7 → no win, because the run does not wrap across a row.
6. rst asserted mid-CHECK and new_game asserted together with move_valid → all outputs at reset values and the move is dropped. With BOARD_GAME_UNDO_EN: X5, undo → cell 5 = 00, turn=0; a second undo → move_err.
